// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate byte cache.
// CPU side: READ/WRITE/ADDRESS/WRITEDATA -> READDATA/BUSYWAIT (stall).
// Memory side: MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA -> 32-bit
// MEM_READDATA with MEM_BUSYWAIT; low at an edge completes the block op.
// CLK rising edge; RESET synchronous active-low; byte0 in bits [7:0].
`timescale 1ns/1ps
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);
    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic                served_q, served_d;
    logic [7:0]          readdata_q, readdata_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [31:0]         fill_q, fill_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [5:0]          mem_address_q, mem_address_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [TAG_BITS-1:0]   a_tag;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            off;
    logic                  req;
    logic                  hit;
    logic                  line_we;
    logic                  byte_we;
    logic [7:0]            byte_sel;

    assign a_tag    = ADDRESS[7:2+INDEX_BITS];
    assign idx      = ADDRESS[2+INDEX_BITS-1:2];
    assign off      = ADDRESS[1:0];
    assign req      = READ | WRITE;
    assign hit      = valid_q[idx] && (tag_q[idx] == a_tag);
    assign byte_sel = data_q[idx][{off, 3'b000} +: 8];

    assign BUSYWAIT      = RESET & req & ~served_q;
    assign READDATA      = readdata_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_address_q;
    assign MEM_WRITEDATA = mem_wdata_q;

    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        readdata_d = readdata_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        fill_d     = fill_q;
        line_we    = 1'b0;
        byte_we    = 1'b0;

        // served only re-arms once the CPU has dropped its request
        if (!req) begin
            served_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (req && !served_q) begin
                    if (hit) begin
                        served_d = 1'b1;
                        if (READ) begin
                            readdata_d = byte_sel;
                        end else begin
                            byte_we      = 1'b1;
                            dirty_d[idx] = 1'b1;
                        end
                    end else if (dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                line_we      = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        line_we = line_we & RESET;
        byte_we = byte_we & RESET;
    end

    // memory strobes follow the state being entered so they are registered
    always_comb begin
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        unique case (1'b1)
            (state_d == WRITEBACK): begin
                mem_write_d   = 1'b1;
                mem_address_d = {tag_q[idx], idx};
                mem_wdata_d   = data_q[idx];
            end
            (state_d == FETCH): begin
                mem_read_d    = 1'b1;
                mem_address_d = {a_tag, idx};
            end
            default: begin
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= IDLE;
            served_q      <= 1'b0;
            readdata_q    <= '0;
            valid_q       <= '0;
            dirty_q       <= '0;
            fill_q        <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            served_q      <= served_d;
            readdata_q    <= readdata_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            fill_q        <= fill_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // tag/data arrays are never cleared; valid bits guard them
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tag_q[idx]  <= a_tag;
            data_q[idx] <= fill_q;
        end else if (byte_we) begin
            data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed bench for data_cache with an architectural
// byte-memory model, a latency-programmable main memory and a bus monitor.
`timescale 1ns/1ps
module tb_data_cache;
    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- main memory: latency per op, one recovery cycle
    logic [31:0] mem [64];
    int          mem_lat = 5;
    int          cnt = 0;
    logic        recover = 1'b0;
    logic        mreq;

    assign mreq         = MEM_READ | MEM_WRITE;
    assign MEM_BUSYWAIT = mreq && !(cnt == mem_lat - 1 && !recover);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (recover) begin
            recover <= 1'b0;
        end else if (!mreq) begin
            cnt <= 0;
        end else if (cnt == mem_lat - 1) begin
            cnt     <= 0;
            recover <= 1'b1;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        end else begin
            cnt <= cnt + 1;
        end
    end

    // ---------------- behavioural model
    logic [7:0]  arch [256];
    logic [31:0] model_mem [64];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag [8];

    logic        mon_en = 1'b0;
    logic        allow_wb = 1'b0;
    logic        allow_fetch = 1'b0;
    logic [5:0]  exp_wb_addr = '0;
    logic [31:0] exp_wb_data = '0;
    logic [5:0]  exp_fetch_addr = '0;
    logic [5:0]  seen_wb_addr = '0;
    logic [31:0] seen_wb_data = '0;
    logic [5:0]  seen_fetch_addr = '0;

    function automatic logic [31:0] arch_block(input logic [5:0] b);
        logic [7:0] base;
        base = {b, 2'b00};
        return {arch[base + 8'd3], arch[base + 8'd2],
                arch[base + 8'd1], arch[base]};
    endfunction

    // bus monitor: every active cycle the memory strobes must match model
    always @(negedge CLK) begin
        if (RESET === 1'b1 && mon_en) begin
            check("mem_excl", 32'(MEM_READ & MEM_WRITE), 32'd0);
            if (MEM_WRITE) begin
                check("wb_expected", 32'(allow_wb), 32'd1);
                check("wb_addr", 32'(MEM_ADDRESS), 32'(exp_wb_addr));
                check("wb_data", MEM_WRITEDATA, exp_wb_data);
                seen_wb_addr = MEM_ADDRESS;
                seen_wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin
                check("fetch_expected", 32'(allow_fetch), 32'd1);
                check("fetch_addr", 32'(MEM_ADDRESS), 32'(exp_fetch_addr));
                seen_fetch_addr = MEM_ADDRESS;
            end
        end
    end

    // one CPU access; called and returns at posedge+1
    task automatic access(input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wd,
                          input int hold,
                          output logic [7:0] rdata, output int lat);
        logic [2:0] idx;
        logic [2:0] tg;
        logic       hit;
        logic       dty;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         cyc;
        idx = addr[4:2];
        tg  = addr[7:5];
        hit = m_valid[idx] && m_tag[idx] == tg;
        dty = m_valid[idx] && m_dirty[idx] && !hit;
        exp_lat = hit ? 1 : (dty ? 2 * mem_lat + 4 : mem_lat + 3);
        exp_wb_addr    = {m_tag[idx], idx};
        exp_wb_data    = arch_block({m_tag[idx], idx});
        exp_fetch_addr = addr[7:2];
        allow_wb       = dty;
        allow_fetch    = !hit;
        exp_rd         = arch[addr];

        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        #1;
        check("busy_raised", 32'(BUSYWAIT), 32'd1);
        cyc = 0;
        while (BUSYWAIT && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        if (rd) check("readdata", 32'(READDATA), 32'(exp_rd));
        rdata = READDATA;
        lat   = cyc;

        if (dty) model_mem[exp_wb_addr] = exp_wb_data;
        if (!hit) m_dirty[idx] = 1'b0;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (wr && !rd) begin
            arch[addr]   = wd;
            m_dirty[idx] = 1'b1;
        end
        allow_wb    = 1'b0;
        allow_fetch = 1'b0;

        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check("hold_busy", 32'(BUSYWAIT), 32'd0);
            if (rd) check("hold_readdata", 32'(READDATA), 32'(exp_rd));
        end
        READ = 1'b0; WRITE = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                for (int k = 0; k < 4; k++) begin
                    arch[{m_tag[i], 3'(i), 2'(k)}] =
                        model_mem[{m_tag[i], 3'(i)}][8*k +: 8];
                end
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int         lat;
        int         cyc;

        for (int a = 0; a < 256; a++) arch[a] = 8'(a) ^ 8'hA5;
        for (int b = 0; b < 64; b++) begin
            mem[b]       = arch_block(6'(b));
            model_mem[b] = arch_block(6'(b));
        end
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end

        RESET = 1'b0; READ = 1'b1; WRITE = 1'b0;
        ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_readdata", 32'(READDATA), 32'd0);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        check("rst_busy_forced", 32'(BUSYWAIT), 32'd0);
        READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        mon_en = 1'b1;

        // clean miss, latency 5
        access(1, 0, 8'h00, 8'h00, 0, rd, lat);
        check("t1_data_lit", 32'(rd), 32'hA5);
        check("t1_lat_lit", 32'(lat), 32'd8);

        // write then read hit on line idx1 tag0
        access(1, 0, 8'h04, 8'h00, 0, rd, lat);
        access(0, 1, 8'h05, 8'hAB, 0, rd, lat);
        check("t2_wr_lat_lit", 32'(lat), 32'd1);
        access(1, 0, 8'h05, 8'h00, 0, rd, lat);
        check("t2_rd_lat_lit", 32'(lat), 32'd1);
        check("t2_data_lit", 32'(rd), 32'hAB);

        // dirty eviction of idx1
        seen_wb_addr = '1; seen_wb_data = '0; seen_fetch_addr = '1;
        access(1, 0, 8'h25, 8'h00, 0, rd, lat);
        check("t3_lat_lit", 32'(lat), 32'd14);
        check("t3_wb_addr_lit", 32'(seen_wb_addr), 32'h01);
        check("t3_wb_byte_lit", 32'(seen_wb_data[15:8]), 32'hAB);
        check("t3_fetch_addr_lit", 32'(seen_fetch_addr), 32'h09);
        check("t3_data_lit", 32'(rd), 32'h80);

        // read+write together behaves as read only
        access(1, 1, 8'h10, 8'h5A, 0, rd, lat);
        check("t4_data_lit", 32'(rd), 32'hB5);
        access(1, 0, 8'h10, 8'h00, 0, rd, lat);
        check("t4_hit_data_lit", 32'(rd), 32'hB5);
        access(1, 0, 8'h30, 8'h00, 0, rd, lat);
        check("t4_clean_evict_lit", 32'(lat), 32'd8);

        // held requests are not re-serviced
        access(1, 0, 8'h30, 8'h00, 3, rd, lat);
        check("t6_data_lit", 32'(rd), 32'h95);
        access(0, 1, 8'h31, 8'h77, 3, rd, lat);

        // reset in the middle of a fetch
        exp_fetch_addr = 6'h11;
        allow_fetch    = 1'b1;
        READ = 1'b1; ADDRESS = 8'h44;
        cyc = 0;
        while (!MEM_READ && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("t5_fetch_started", 32'(MEM_READ), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        check("t5_busy_in_reset", 32'(BUSYWAIT), 32'd0);
        @(posedge CLK); #1;
        check("t5_mem_read_drop", 32'(MEM_READ), 32'd0);
        check("t5_mem_addr_zero", 32'(MEM_ADDRESS), 32'd0);
        model_reset();
        READ = 1'b0; allow_fetch = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        access(1, 0, 8'h44, 8'h00, 0, rd, lat);
        check("t5_refetch_lat_lit", 32'(lat), 32'd8);
        check("t5_data_lit", 32'(rd), 32'hE1);
        access(1, 0, 8'h31, 8'h00, 0, rd, lat);
        check("t5_dirty_lost_lat_lit", 32'(lat), 32'd8);
        check("t5_dirty_lost_lit", 32'(rd), 32'h94);

        // short memory latency, write-allocate and write-back round trip
        mem_lat = 2;
        access(0, 1, 8'h85, 8'h3C, 0, rd, lat);
        check("t7_wr_miss_lat_lit", 32'(lat), 32'd5);
        access(0, 1, 8'hC6, 8'hD2, 0, rd, lat);
        check("t7_wr_dirty_lat_lit", 32'(lat), 32'd8);
        access(1, 0, 8'h85, 8'h00, 1, rd, lat);
        check("t7_roundtrip_lit", 32'(rd), 32'h3C);
        access(1, 0, 8'hC6, 8'h00, 0, rd, lat);
        check("t7_roundtrip2_lit", 32'(rd), 32'hD2);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
